keypad_scan_ctrl: RTL and testbench

Sequencing controller for the 4x4 keypad datapath. It drives the row strobes, detects a key press on the synchronized column inputs, and debounces both press and release. It locks onto one key until that key is released, then emits a single-cycle key-valid pulse with a 4-bit key code. It sits between the column synchronizer and the two-digit storage/display path on the 10 kHz domain.

---
 rtl/keypad_pkg.sv | 43 ++++
 rtl/keypad_db_counter.sv | 45 ++++
 rtl/keypad_scan_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
// Shared types and helpers for the 4x4 keypad scan controller.
//   kp_state_e  : controller states (SCAN, DB_PRESS, HELD, DB_RELEASE)
//   KEYMAP      : key code per [row][column]
//   onehotToIdx : one-hot (4 bit) to 2-bit index
//   isOneHot    : true when exactly one of four bits is set
// ---------------------------------------------------------------------------
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } kp_state_e;

  // Physical keypad legend, indexed [row][column].
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic logic [1:0] onehotToIdx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    case (oh)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Clearing the lowest set bit leaves zero only for a single-bit value.
  function automatic logic isOneHot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/keypad_db_counter.sv
// ---------------------------------------------------------------------------
// keypad_db_counter
// Clearable saturating up-counter with enable and terminal-count flag. Used
// for the row dwell, press/release debounce and held-key repeat timers.
//   clk_i   : clock
//   reset_i : asynchronous active-high reset (count -> 0)
//   clr_i   : synchronous clear, wins over enable
//   en_i    : count enable; the count stops at TERMINAL
//   tc_o    : high while the count equals TERMINAL
// ---------------------------------------------------------------------------
module keypad_db_counter #(
  parameter int WIDTH    = 8,
  parameter int TERMINAL = 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign tc_o = (cnt_q == WIDTH'(TERMINAL));

  // Saturation keeps the count from wrapping if a caller leaves en_i high.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// ---------------------------------------------------------------------------
// keypad_scan_ctrl
// Sequencing controller for the 4x4 keypad: strobes rows, detects a single
// pressed key on the synchronized columns, debounces press and release, locks
// onto that key until it is released, and emits a one-cycle key_valid pulse
// with the key code.
//   clk       : 10 kHz scan clock
//   reset     : asynchronous active-high reset
//   col       : synchronized column sense, active-high
//   row       : one-hot active-high row strobe
//   key_code  : code of the last accepted key, held until the next pulse
//   key_valid : one-cycle pulse, key_code valid in the same cycle
//   key_held  : high while the locked key is considered pressed
// Optional build macro: KEYPAD_REPEAT_EN adds auto-repeat every
// REPEAT_CYCLES cycles while a key stays held.
// SCAN_DIV must be at least 4 so the column synchronizer settles before the
// row is sampled.
// ---------------------------------------------------------------------------
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 10,
  parameter int DEBOUNCE_CYCLES = 200,
  parameter int REPEAT_CYCLES   = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int MAX_A     = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int MAX_PARAM = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
  localparam int CNT_W     = $clog2(MAX_PARAM);

  kp_state_e  state_q, state_d;
  logic [3:0] row_q, row_d;
  logic [3:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic [1:0] rowIdx_q, rowIdx_d;
  logic [1:0] colIdx_q, colIdx_d;

  logic       dwellClr, dwellEn, dwellTc;
  logic       dbClr, dbEn, dbTc;
  logic [3:0] colSel;
  logic       colMatch;
  logic       colHeld;
  logic [3:0] rowNext;

  assign colSel   = 4'b0001 << colIdx_q;
  // Press debounce needs the exact captured pattern; release only watches
  // the locked column so other keys cannot disturb the lock.
  assign colMatch = (col == colSel);
  assign colHeld  = col[colIdx_q];
  assign rowNext  = {row_q[2:0], row_q[3]};

  keypad_db_counter #(.WIDTH(CNT_W), .TERMINAL(SCAN_DIV - 1)) u_dwell (
    .clk_i   (clk),
    .reset_i (reset),
    .clr_i   (dwellClr),
    .en_i    (dwellEn),
    .tc_o    (dwellTc)
  );

  keypad_db_counter #(.WIDTH(CNT_W), .TERMINAL(DEBOUNCE_CYCLES - 1)) u_debounce (
    .clk_i   (clk),
    .reset_i (reset),
    .clr_i   (dbClr),
    .en_i    (dbEn),
    .tc_o    (dbTc)
  );

`ifdef KEYPAD_REPEAT_EN
  logic repClr, repEn, repTc;

  keypad_db_counter #(.WIDTH(CNT_W), .TERMINAL(REPEAT_CYCLES - 1)) u_repeat (
    .clk_i   (clk),
    .reset_i (reset),
    .clr_i   (repClr),
    .en_i    (repEn),
    .tc_o    (repTc)
  );
`endif

  // Next-state logic. Counters are held clear outside the states that use
  // them, so each one starts from zero on entry to its state.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    code_d   = code_q;
    valid_d  = 1'b0;
    rowIdx_d = rowIdx_q;
    colIdx_d = colIdx_q;
    dwellClr = 1'b1;
    dwellEn  = 1'b0;
    dbClr    = 1'b1;
    dbEn     = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    repClr   = 1'b1;
    repEn    = 1'b0;
`endif

    case (state_q)
      SCAN: begin
        dwellClr = 1'b0;
        dwellEn  = 1'b1;
        if (dwellTc) begin
          dwellClr = 1'b1;
          if (isOneHot(col)) begin
            rowIdx_d = onehotToIdx(row_q);
            colIdx_d = onehotToIdx(col);
            state_d  = DB_PRESS;
          end else begin
            row_d = rowNext;
          end
        end
      end

      // A mismatch drops back to SCAN with the row still frozen, giving the
      // same row one full dwell before rotation resumes.
      DB_PRESS: begin
        dbClr = 1'b0;
        if (!colMatch) begin
          dbClr   = 1'b1;
          state_d = SCAN;
        end else if (dbTc) begin
          dbClr   = 1'b1;
          state_d = HELD;
          valid_d = 1'b1;
          code_d  = KEYMAP[rowIdx_q][colIdx_q];
        end else begin
          dbEn = 1'b1;
        end
      end

      HELD: begin
        if (!colHeld) begin
          state_d = DB_RELEASE;
        end
`ifdef KEYPAD_REPEAT_EN
        else begin
          repClr = 1'b0;
          repEn  = 1'b1;
          if (repTc) begin
            repClr  = 1'b1;
            valid_d = !valid_q;
          end
        end
`endif
      end

      DB_RELEASE: begin
        dbClr = 1'b0;
        if (colHeld) begin
          dbClr   = 1'b1;
          state_d = HELD;
        end else if (dbTc) begin
          dbClr   = 1'b1;
          state_d = SCAN;
          row_d   = rowNext;
        end else begin
          dbEn = 1'b1;
        end
      end

      default: begin
        state_d = SCAN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= SCAN;
      row_q    <= 4'b0001;
      code_q   <= 4'h0;
      valid_q  <= 1'b0;
      rowIdx_q <= 2'd0;
      colIdx_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      rowIdx_q <= rowIdx_d;
      colIdx_q <= colIdx_d;
    end
  end

  assign row       = row_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = (state_q == HELD) || (state_q == DB_RELEASE);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_keypad_scan_ctrl
// Directed bench for keypad_scan_ctrl with default parameters. A small keypad
// model turns a 16-bit pressed-key map (bit r*4+c) into column sense for the
// currently strobed row. Cycle numbers count falling edges after reset
// release; edge k follows the k-th rising edge. With SCAN_DIV=10 the first
// sample of row 0 happens at edge 10, and a press captured at edge N pulses
// at edge N+200 (201st cycle counting the sampling cycle).
// Build with +define+KEYPAD_REPEAT_EN to expect auto-repeat pulses.
// ---------------------------------------------------------------------------
module tb_keypad_scan_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] keys;
  logic        bounce;
  int          cyc;
  int          checks;
  int          errors;

  keypad_scan_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a pressed key shows on its column only while its row is driven.
  always_comb begin
    col = 4'b0000;
    for (int r = 0; r < 4; r++) begin
      if (row[r]) col = col | keys[r*4 +: 4];
    end
    if (bounce) col = 4'b0000;
  end

  task automatic doReset(input logic [15:0] k);
    @(negedge clk);
    reset  = 1'b1;
    keys   = k;
    bounce = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    logic [3:0] expRow;
    doReset(16'h0000);
    while (cyc < 25) step();
    checks++; if (row !== 4'b0100) begin errors++; $display("[TB] FAIL pre_reset_row: got %b expected 0100", row); end
    #2 reset = 1'b1;
    #1;
    checks++; if (row !== 4'b0001) begin errors++; $display("[TB] FAIL reset_row: got %b expected 0001", row); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", key_valid); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("[TB] FAIL reset_code: got %h expected 0", key_code); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("[TB] FAIL reset_held: got %b expected 0", key_held); end
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
    while (cyc < 45) begin
      step();
      expRow = 4'(1 << ((cyc / 10) % 4));
      checks++; if (row !== expRow) begin errors++; $display("[TB] FAIL rotate_row cyc %0d: got %b expected %b", cyc, row, expRow); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL rotate_valid cyc %0d: got %b expected 0", cyc, key_valid); end
    end
  endtask

  task automatic test_hold_key5();
    int         nPulse;
    int         pulseCyc;
    logic [3:0] pulseCode;
    int         heldCnt;
    bit         released;
    nPulse = 0; pulseCyc = -1; pulseCode = 4'h0;
    doReset(16'h0020);
    while (cyc < 400) begin
      step();
      if (key_valid === 1'b1) begin
        nPulse++;
        if (nPulse == 1) begin pulseCyc = cyc; pulseCode = key_code; end
      end
      if (cyc == 219) begin
        checks++; if (key_held !== 1'b0) begin errors++; $display("[TB] FAIL hold5_held_early: got %b expected 0", key_held); end
      end
    end
    checks++; if (nPulse !== 1) begin errors++; $display("[TB] FAIL hold5_pulse_count: got %0d expected 1", nPulse); end
    checks++; if (pulseCyc !== 220) begin errors++; $display("[TB] FAIL hold5_pulse_cycle: got %0d expected 220", pulseCyc); end
    checks++; if (pulseCode !== 4'h5) begin errors++; $display("[TB] FAIL hold5_code: got %h expected 5", pulseCode); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("[TB] FAIL hold5_held: got %b expected 1", key_held); end
    keys = 16'h0000;
    heldCnt = 0; released = 1'b0;
    for (int i = 0; i < 300 && !released; i++) begin
      step();
      if (key_held === 1'b1) heldCnt++;
      else released = 1'b1;
      if (key_valid === 1'b1) nPulse++;
    end
    checks++; if (heldCnt !== 200) begin errors++; $display("[TB] FAIL release5_held_cycles: got %0d expected 200", heldCnt); end
    checks++; if (row !== 4'b0100) begin errors++; $display("[TB] FAIL release5_row: got %b expected 0100", row); end
    checks++; if (nPulse !== 1) begin errors++; $display("[TB] FAIL release5_pulse_count: got %0d expected 1", nPulse); end
    checks++; if (key_code !== 4'h5) begin errors++; $display("[TB] FAIL release5_code_kept: got %h expected 5", key_code); end
  endtask

  task automatic test_bounce9();
    int         nPulse;
    int         pulseCyc;
    logic [3:0] pulseCode;
    nPulse = 0; pulseCyc = -1; pulseCode = 4'h0;
    doReset(16'h0400);
    while (cyc < 400) begin
      step();
      if (cyc == 80) bounce = 1'b1;
      if (cyc == 81) bounce = 1'b0;
      if (key_valid === 1'b1) begin
        nPulse++;
        if (nPulse == 1) begin pulseCyc = cyc; pulseCode = key_code; end
      end
      if (cyc == 85) begin
        checks++; if (row !== 4'b0100) begin errors++; $display("[TB] FAIL bounce9_row_frozen: got %b expected 0100", row); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("[TB] FAIL bounce9_held: got %b expected 0", key_held); end
      end
    end
    checks++; if (nPulse !== 1) begin errors++; $display("[TB] FAIL bounce9_pulse_count: got %0d expected 1", nPulse); end
    checks++; if (pulseCyc !== 291) begin errors++; $display("[TB] FAIL bounce9_pulse_cycle: got %0d expected 291", pulseCyc); end
    checks++; if (pulseCode !== 4'h9) begin errors++; $display("[TB] FAIL bounce9_code: got %h expected 9", pulseCode); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("[TB] FAIL bounce9_held_after: got %b expected 1", key_held); end
  endtask

  task automatic test_lock_1_then_2();
    int         nPulse;
    int         pulseCyc [2];
    logic [3:0] pulseCode [2];
    nPulse = 0;
    pulseCyc  = '{-1, -1};
    pulseCode = '{4'h0, 4'h0};
    doReset(16'h0001);
    while (cyc < 800) begin
      step();
      if (cyc == 250) keys = 16'h0003;
      if (cyc == 300) keys = 16'h0002;
      if (key_valid === 1'b1) begin
        if (nPulse < 2) begin pulseCyc[nPulse] = cyc; pulseCode[nPulse] = key_code; end
        nPulse++;
      end
      if (cyc == 400) begin
        checks++; if (key_held !== 1'b1) begin errors++; $display("[TB] FAIL lock_held_in_release: got %b expected 1", key_held); end
      end
      if (cyc == 502) begin
        checks++; if (row !== 4'b0010) begin errors++; $display("[TB] FAIL lock_row_after_release: got %b expected 0010", row); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("[TB] FAIL lock_held_after_release: got %b expected 0", key_held); end
      end
    end
    checks++; if (nPulse !== 2) begin errors++; $display("[TB] FAIL lock_pulse_count: got %0d expected 2", nPulse); end
    checks++; if (pulseCyc[0] !== 210) begin errors++; $display("[TB] FAIL lock_pulse1_cycle: got %0d expected 210", pulseCyc[0]); end
    checks++; if (pulseCode[0] !== 4'h1) begin errors++; $display("[TB] FAIL lock_pulse1_code: got %h expected 1", pulseCode[0]); end
    checks++; if (pulseCyc[1] !== 741) begin errors++; $display("[TB] FAIL lock_pulse2_cycle: got %0d expected 741", pulseCyc[1]); end
    checks++; if (pulseCode[1] !== 4'h2) begin errors++; $display("[TB] FAIL lock_pulse2_code: got %h expected 2", pulseCode[1]); end
  endtask

  task automatic test_multi_key_and_abort();
    int nPulse;
    nPulse = 0;
    doReset(16'h0005);
    while (cyc < 60) begin
      step();
      if (key_valid === 1'b1) nPulse++;
      if (cyc == 10 || cyc == 50) begin
        checks++; if (row !== 4'b0010) begin errors++; $display("[TB] FAIL multi_row cyc %0d: got %b expected 0010", cyc, row); end
      end
      if (cyc == 40) begin
        checks++; if (row !== 4'b0001) begin errors++; $display("[TB] FAIL multi_row cyc 40: got %b expected 0001", row); end
      end
    end
    checks++; if (nPulse !== 0) begin errors++; $display("[TB] FAIL multi_pulse_count: got %0d expected 0", nPulse); end

    nPulse = 0;
    doReset(16'h0020);
    while (cyc < 500) begin
      step();
      if (cyc == 230) keys = 16'h0100;
      if (key_valid === 1'b1) nPulse++;
      if (cyc == 499) begin
        checks++; if (key_held !== 1'b0) begin errors++; $display("[TB] FAIL abort_held_pre: got %b expected 0", key_held); end
        checks++; if (row !== 4'b0100) begin errors++; $display("[TB] FAIL abort_row_pre: got %b expected 0100", row); end
      end
    end
    checks++; if (nPulse !== 1) begin errors++; $display("[TB] FAIL abort_first_pulses: got %0d expected 1", nPulse); end
    checks++; if (key_code !== 4'h5) begin errors++; $display("[TB] FAIL abort_code_pre: got %h expected 5", key_code); end
    #2 reset = 1'b1;
    #1;
    checks++; if (row !== 4'b0001) begin errors++; $display("[TB] FAIL abort_row: got %b expected 0001", row); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("[TB] FAIL abort_code: got %h expected 0", key_code); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_valid: got %b expected 0", key_valid); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("[TB] FAIL abort_held: got %b expected 0", key_held); end
    @(negedge clk);
    keys  = 16'h0000;
    reset = 1'b0;
    cyc   = 0;
    nPulse = 0;
    while (cyc < 300) begin
      step();
      if (key_valid === 1'b1) nPulse++;
    end
    checks++; if (nPulse !== 0) begin errors++; $display("[TB] FAIL abort_post_pulses: got %0d expected 0", nPulse); end
  endtask

  task automatic test_repeat_keyA();
    int         nPulse;
    int         pulseCyc [3];
    logic [3:0] pulseCode [3];
`ifdef KEYPAD_REPEAT_EN
    localparam int EXP_PULSES = 3;
`else
    localparam int EXP_PULSES = 1;
`endif
    nPulse = 0;
    pulseCyc  = '{-1, -1, -1};
    pulseCode = '{4'h0, 4'h0, 4'h0};
    doReset(16'h0008);
    while (cyc < 11210) begin
      step();
      if (key_valid === 1'b1) begin
        if (nPulse < 3) begin pulseCyc[nPulse] = cyc; pulseCode[nPulse] = key_code; end
        nPulse++;
      end
    end
    checks++; if (nPulse !== EXP_PULSES) begin errors++; $display("[TB] FAIL repeat_pulse_count: got %0d expected %0d", nPulse, EXP_PULSES); end
    checks++; if (pulseCyc[0] !== 210) begin errors++; $display("[TB] FAIL repeat_first_cycle: got %0d expected 210", pulseCyc[0]); end
    checks++; if (pulseCode[0] !== 4'hA) begin errors++; $display("[TB] FAIL repeat_first_code: got %h expected A", pulseCode[0]); end
`ifdef KEYPAD_REPEAT_EN
    checks++; if (pulseCyc[1] !== 5210) begin errors++; $display("[TB] FAIL repeat_second_cycle: got %0d expected 5210", pulseCyc[1]); end
    checks++; if (pulseCode[1] !== 4'hA) begin errors++; $display("[TB] FAIL repeat_second_code: got %h expected A", pulseCode[1]); end
    checks++; if (pulseCyc[2] !== 10210) begin errors++; $display("[TB] FAIL repeat_third_cycle: got %0d expected 10210", pulseCyc[2]); end
    checks++; if (pulseCode[2] !== 4'hA) begin errors++; $display("[TB] FAIL repeat_third_code: got %h expected A", pulseCode[2]); end
`endif
  endtask

  initial begin
    reset  = 1'b1;
    keys   = 16'h0000;
    bounce = 1'b0;
    cyc    = 0;
    checks = 0;
    errors = 0;
    test_reset();
    test_hold_key5();
    test_bounce9();
    test_lock_1_then_2();
    test_multi_key_and_abort();
    test_repeat_keyA();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
